// File: rtl/bloco_controle_if.sv
// rtl/bloco_controle_if.sv - control bundle between bloco_controle and its datapath/driver
interface bloco_controle_if;
  logic       start;
  logic       LX;
  logic       LS;
  logic       LH;
  logic       h;
  logic [1:0] m0;
  logic [1:0] m1;
  logic [1:0] m2;
  logic       busy;
  logic       done;

  modport master (
    output start,
    input  LX, LS, LH, h, m0, m1, m2, busy, done
  );

  modport slave (
    input  start,
    output LX, LS, LH, h, m0, m1, m2, busy, done
  );
endinterface

// File: rtl/bloco_controle.sv
// rtl/bloco_controle.sv - Moore FSM sequencing y = a*x*x + b*x + c on the datapath
module bloco_controle #(
  parameter int ULA_WAIT = 0
) (
  input  logic             clock,
  input  logic             reset,
  bloco_controle_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LDX, S_MUL1, S_ADD1, S_MUL2, S_ADD2, S_DONE
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(ULA_WAIT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       w_compute;
  logic       w_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_compute = (r_state == S_MUL1) || (r_state == S_ADD1) ||
                (r_state == S_MUL2) || (r_state == S_ADD2);
    w_last    = w_compute && (r_cnt == WAIT_LAST);
    w_next    = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_LDX;
      S_LDX:   w_next = S_MUL1;
      S_MUL1:  if (w_last) w_next = S_ADD1;
      S_ADD1:  if (w_last) w_next = S_MUL2;
      S_MUL2:  if (w_last) w_next = S_ADD2;
      S_ADD2:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Counter restarts on every state change so each compute step starts at zero
    if (w_next != r_state)
      w_cnt_next = 4'd0;
    else if (w_compute && !w_last)
      w_cnt_next = r_cnt + 4'd1;
    else
      w_cnt_next = r_cnt;
  end

  always_comb begin
    bus.LX   = 1'b0;
    bus.LS   = 1'b0;
    bus.LH   = 1'b0;
    bus.h    = 1'b0;
    bus.m0   = 2'b00;
    bus.m1   = 2'b00;
    bus.m2   = 2'b00;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      S_LDX: begin
        bus.LX   = 1'b1;
        bus.busy = 1'b1;
      end
      S_MUL1: begin
        bus.h    = 1'b1;
        bus.LH   = w_last;
        bus.busy = 1'b1;
      end
      S_ADD1: begin
        bus.m0   = 2'b10;
        bus.m2   = 2'b11;
        bus.LS   = w_last;
        bus.busy = 1'b1;
      end
      S_MUL2: begin
        bus.h    = 1'b1;
        bus.m1   = 2'b10;
        bus.LH   = w_last;
        bus.busy = 1'b1;
      end
      S_ADD2: begin
        bus.m0   = 2'b11;
        bus.m2   = 2'b11;
        bus.LS   = w_last;
        bus.busy = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bloco_controle.sv
// tb/tb_bloco_controle.sv - randomized bench with a behavioural datapath and polynomial reference
module tb_bloco_controle;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bloco_controle_if if0();
  bloco_controle_if if2();

  bloco_controle #(.ULA_WAIT(0)) u_w0 (.clock(clock), .reset(reset), .bus(if0));
  bloco_controle #(.ULA_WAIT(2)) u_w2 (.clock(clock), .reset(reset), .bus(if2));

  int total = 0;
  int bad   = 0;
  int ra, rb, rc, rx;
  int dp_x[2], dp_s[2], dp_h[2];

  function automatic int ula(input logic h, input logic [1:0] m0, input logic [1:0] m1,
                             input logic [1:0] m2, input int xr, input int sr, input int hr);
    int op, opa, opb;
    op = (m0 == 2'b10) ? rb : (m0 == 2'b11) ? rc : ra;
    case (m1)
      2'b00:   opb = op;
      2'b01:   opb = xr;
      2'b10:   opb = sr;
      default: opb = hr;
    endcase
    case (m2)
      2'b00:   opa = xr;
      2'b01:   opa = op;
      2'b10:   opa = sr;
      default: opa = hr;
    endcase
    return h ? opa * opb : opa + opb;
  endfunction

  always @(posedge clock) begin
    if (if0.LX) dp_x[0] <= rx;
    if (if0.LH) dp_h[0] <= ula(if0.h, if0.m0, if0.m1, if0.m2, dp_x[0], dp_s[0], dp_h[0]);
    if (if0.LS) dp_s[0] <= ula(if0.h, if0.m0, if0.m1, if0.m2, dp_x[0], dp_s[0], dp_h[0]);
    if (if2.LX) dp_x[1] <= rx;
    if (if2.LH) dp_h[1] <= ula(if2.h, if2.m0, if2.m1, if2.m2, dp_x[1], dp_s[1], dp_h[1]);
    if (if2.LS) dp_s[1] <= ula(if2.h, if2.m0, if2.m1, if2.m2, dp_x[1], dp_s[1], dp_h[1]);
  end

  function automatic int poly();
    return ra * rx * rx + rb * rx + rc;
  endfunction

  function automatic logic [11:0] outs(input int sel);
    if (sel == 0)
      return {if0.LX, if0.LS, if0.LH, if0.h, if0.m0, if0.m1, if0.m2, if0.busy, if0.done};
    return {if2.LX, if2.LS, if2.LH, if2.h, if2.m0, if2.m1, if2.m2, if2.busy, if2.done};
  endfunction

  task automatic drive_start(input int sel, input logic v);
    if (sel == 0) if0.start = v;
    else          if2.start = v;
  endtask

  // Expected outputs k cycles after the accepting edge, from the step table
  function automatic logic [11:0] exp_vec(input int k, input int w);
    int len = 2 + 4 * (w + 1);
    int ph;
    logic lx = 0, ls = 0, lh = 0, h = 0, bz = 0, dn = 0, last = 0;
    logic [1:0] m0 = 2'b00, m1 = 2'b00, m2 = 2'b00;
    if (k == 1) begin
      lx = 1; bz = 1;
    end else if (k >= 2 && k < len) begin
      ph   = (k - 2) / (w + 1);
      last = (((k - 2) % (w + 1)) == w);
      bz   = 1;
      case (ph)
        0:       begin h = 1; lh = last; end
        1:       begin m0 = 2'b10; m2 = 2'b11; ls = last; end
        2:       begin h = 1; m1 = 2'b10; lh = last; end
        default: begin m0 = 2'b11; m2 = 2'b11; ls = last; end
      endcase
    end else if (k == len) begin
      dn = 1;
    end
    return {lx, ls, lh, h, m0, m1, m2, bz, dn};
  endfunction

  task automatic run_eval(input string name, input int sel, input int w,
                          input int av, input int bv, input int cv, input int xv,
                          input int inj1, input int inj2);
    int len = 2 + 4 * (w + 1);
    int done_k = -1;
    int ndone = 0;
    int nbusy = 0;
    logic [11:0] got, want;
    ra = av; rb = bv; rc = cv; rx = xv;
    @(negedge clock);
    drive_start(sel, 1'b1);
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge clock);
      got  = outs(sel);
      want = exp_vec(k, w);
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s cycle %0d outputs got=%b want=%b", name, k, got, want);
      end
      if (got[1] === 1'b1) nbusy++;
      if (got[0] === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
        total++;
        if (dp_s[sel] !== poly()) begin
          bad++;
          $display("FAIL %s result got=%0d want=%0d", name, dp_s[sel], poly());
        end
      end
      drive_start(sel, (k == inj1) || (k == inj2));
    end
    drive_start(sel, 1'b0);
    total++;
    if (done_k !== len) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", name, done_k, len);
    end
    total++;
    if (ndone !== 1) begin
      bad++;
      $display("FAIL %s done_pulses got=%0d want=1", name, ndone);
    end
    total++;
    if (nbusy !== len - 1) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", name, nbusy, len - 1);
    end
  endtask

  task automatic test_reset();
    if0.start = 1'b0;
    if2.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (outs(0) !== 12'd0) begin
      bad++;
      $display("FAIL reset_w0 got=%b want=0", outs(0));
    end
    total++;
    if (outs(1) !== 12'd0) begin
      bad++;
      $display("FAIL reset_w2 got=%b want=0", outs(1));
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_eval("basic_w0", 0, 0, 2, 3, 4, 5, -1, -1);
    total++;
    if (dp_s[0] !== 69) begin
      bad++;
      $display("FAIL basic_value got=%0d want=69", dp_s[0]);
    end
  endtask

  task automatic test_wait();
    run_eval("wait_w2", 1, 2, -3, 7, -10, 4, -1, -1);
    total++;
    if (dp_s[1] !== -30) begin
      bad++;
      $display("FAIL wait_value got=%0d want=-30", dp_s[1]);
    end
  endtask

  task automatic test_ignore_start();
    run_eval("ignore_w0", 0, 0, 6, -2, 9, -3, 2, 5);
    run_eval("ignore_w2", 1, 2, -4, 5, 1, 7, 3, 2 + 3 * 3);
  endtask

  task automatic test_reset_mid();
    int saved;
    logic [11:0] got;
    ra = 5; rb = 6; rc = 7; rx = 3;
    @(negedge clock);
    if0.start = 1'b1;
    @(negedge clock);
    if0.start = 1'b0;
    repeat (2) @(negedge clock);
    saved = dp_s[0];
    #2 reset = 1'b1;
    #1;
    total++;
    if (outs(0) !== 12'd0) begin
      bad++;
      $display("FAIL reset_async got=%b want=0", outs(0));
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      got = outs(0);
      total++;
      if (got !== 12'd0) begin
        bad++;
        $display("FAIL reset_abort cycle %0d got=%b want=0", k, got);
      end
    end
    total++;
    if (dp_s[0] !== saved) begin
      bad++;
      $display("FAIL reset_no_load got=%0d want=%0d", dp_s[0], saved);
    end
    run_eval("after_reset", 0, 0, 1, 0, 0, -8, -1, -1);
    total++;
    if (dp_s[0] !== 64) begin
      bad++;
      $display("FAIL after_reset_value got=%0d want=64", dp_s[0]);
    end
  endtask

  task automatic test_back_to_back();
    int dk[$];
    int nload;
    ra = int'($urandom_range(40)) - 20;
    rb = int'($urandom_range(40)) - 20;
    rc = int'($urandom_range(40)) - 20;
    rx = int'($urandom_range(40)) - 20;
    @(negedge clock);
    if0.start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      nload = int'(if0.LX) + int'(if0.LS) + int'(if0.LH);
      total++;
      if (nload > 1) begin
        bad++;
        $display("FAIL b2b_overlap cycle %0d got=%0d want<=1", k, nload);
      end
      if (if0.done === 1'b1) begin
        dk.push_back(k);
        total++;
        if (dp_s[0] !== poly()) begin
          bad++;
          $display("FAIL b2b_result got=%0d want=%0d", dp_s[0], poly());
        end
      end
      if (k == 19) if0.start = 1'b0;
    end
    total++;
    if (dk.size() !== 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=3", dk.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        total++;
        if (dk[i] - dk[i-1] !== 7) begin
          bad++;
          $display("FAIL b2b_period got=%0d want=7", dk[i] - dk[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_eval("random", i % 2, (i % 2 == 0) ? 0 : 2,
               int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100,
               int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100,
               -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
